// File: rtl/fir_stream_driver.sv
// fir_stream_driver: buffers tagged host bytes in a FIFO and replays them to
// the FIR input at a programmable pace, switching the coeff/sample mode line.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable, flush         pace enable, sync clear of FIFO/FSM/mode
//   rate_div              emit opportunity every rate_div+1 cycles
//   wr_en/wr_coeff/wr_data host write strobe, tag, byte
//   full/empty/level      FIFO status
//   overflow              sticky rejected-write flag
//   x_n/s_axis_fir_tvalid/s_set_coeffs  FIR-side outputs
module fir_stream_driver #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int RATE_W     = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [RATE_W-1:0] rate_div,
  input  logic              wr_en,
  input  logic              wr_coeff,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [DATA_W-1:0] x_n,
  output logic              s_axis_fir_tvalid,
  output logic              s_set_coeffs
);

  typedef struct packed {
    logic              tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    EMIT
  } state_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head;
  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic [RATE_W-1:0] cnt;
  logic              tick;
  logic              wr_ok;
  logic              pop;
  logic              same;

  assign level = count;
  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign head  = mem[rd_ptr];
  assign same  = (head.tag == s_set_coeffs);
  assign tick  = enable && (cnt == '0);
  assign wr_ok = wr_en && !full && !flush;

  // SWITCH pops without a tick so data
  // follows the mode change by one cycle.
  always_comb begin
    pop = 1'b0;
    if (!flush) begin
      case (state)
        IDLE, EMIT: pop = tick && !empty && same;
        SWITCH:     pop = !empty;
        default:    pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= '{tag: wr_coeff, data: wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= rate_div;
    end else if (enable) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      x_n               <= '0;
    end else if (flush) begin
      state             <= IDLE;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
    end else begin
      s_axis_fir_tvalid <= 1'b0;
      case (state)
        IDLE, EMIT: begin
          if (tick && !empty) begin
            if (same) begin
              state             <= EMIT;
              s_axis_fir_tvalid <= 1'b1;
              x_n               <= head.data;
            end else begin
              state        <= SWITCH;
              s_set_coeffs <= head.tag;
            end
          end else begin
            state <= IDLE;
          end
        end
        SWITCH: begin
          if (!empty) begin
            state             <= EMIT;
            s_axis_fir_tvalid <= 1'b1;
            x_n               <= head.data;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
